// File: rtl/mem_stage_if.sv
// Data-memory port of the memory-access stage: registered request side, ack/rdata completion side.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: byte/half/word loads and stores over req/ack, 1-cycle ALU passthrough, >=2 cycles
// for memory ops; stall_out holds upstream while an access is outstanding. Optional ack timeout: MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [6:0]  ctrl_in,
  input  logic [2:0]  dst_idx_in,
  input  logic [31:0] execute_result_in,
  input  logic [31:0] store_data_in,
  output logic        stall_out,
  mem_stage_if.master dmem,
  output logic        valid_out,
  output logic [6:0]  ctrl_out,
  output logic [2:0]  dst_idx_out,
  output logic [31:0] wb_data_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] exe_q;
  logic        rd_q;

  logic        is_mem;
  logic        misaligned;
  logic        accept;
  logic        timeout;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] load_data;
  logic [31:0] shifted;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign is_mem = ctrl_in[0] | ctrl_in[1];
  assign accept = valid_in & is_mem & ~misaligned;

  always_comb begin
    misaligned = 1'b0;
    be_nxt     = 4'b1111;
    wdata_nxt  = store_data_in;
    case (ctrl_in[4:3])
      2'b00: begin
        be_nxt    = 4'b0001 << execute_result_in[1:0];
        wdata_nxt = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        misaligned = execute_result_in[0];
        be_nxt     = execute_result_in[1] ? 4'b1100 : 4'b0011;
        wdata_nxt  = {2{store_data_in[15:0]}};
      end
      default: misaligned = |execute_result_in[1:0];
    endcase
  end

  // Lane select and extension use the size/sign bits latched at acceptance.
  always_comb begin
    shifted   = dmem.dmem_rdata >> {exe_q[1:0], 3'b000};
    load_data = dmem.dmem_rdata;
    case (ctrl_out[4:3])
      2'b00:   load_data = ctrl_out[5] ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      2'b01:   load_data = ctrl_out[5] ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default: load_data = dmem.dmem_rdata;
    endcase
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          bus_err_q;

  assign timeout     = (state == REQ) && !dmem.dmem_ack && (to_cnt == CW'(TIMEOUT_CYCLES));
  assign bus_err_out = bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
      end else if (timeout) begin
        bus_err_q <= 1'b1;
      end else if (!dmem.dmem_ack) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout     = 1'b0;
  assign bus_err_out = 1'b0;
`endif

  assign stall_out = (state == IDLE) ? accept : (!dmem.dmem_ack && !timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      exe_q        <= '0;
      rd_q         <= 1'b0;
      valid_out    <= 1'b0;
      ctrl_out     <= '0;
      dst_idx_out  <= '0;
      wb_data_out  <= '0;
      misalign_out <= 1'b0;
    end else begin
      misalign_out <= 1'b0;
      case (state)
        IDLE: begin
          ctrl_out    <= ctrl_in;
          dst_idx_out <= dst_idx_in;
          exe_q       <= execute_result_in;
          if (valid_in && is_mem) begin
            valid_out <= 1'b0;
            if (misaligned) begin
              misalign_out <= 1'b1;
            end else begin
              // Read+write together is a write: the write wins, no load data returned.
              req_q   <= 1'b1;
              we_q    <= ctrl_in[1];
              rd_q    <= ctrl_in[0] & ~ctrl_in[1];
              addr_q  <= {execute_result_in[31:2], 2'b00};
              be_q    <= be_nxt;
              wdata_q <= wdata_nxt;
              state   <= REQ;
            end
          end else begin
            valid_out   <= valid_in;
            wb_data_out <= execute_result_in;
          end
        end
        REQ: begin
          if (dmem.dmem_ack) begin
            req_q       <= 1'b0;
            valid_out   <= 1'b1;
            wb_data_out <= (ctrl_out[6] && rd_q) ? load_data : exe_q;
            state       <= IDLE;
          end else if (timeout) begin
            req_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, loads, stores, alignment, reset abort and ack timeout.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [6:0]  ctrl_in;
  logic [2:0]  dst_idx_in;
  logic [31:0] execute_result_in;
  logic [31:0] store_data_in;
  logic        stall_out;
  logic        valid_out;
  logic [6:0]  ctrl_out;
  logic [2:0]  dst_idx_out;
  logic [31:0] wb_data_out;
  logic        misalign_out;
  logic        bus_err_out;

  int vectors = 0;
  int miscompares = 0;

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_in          (valid_in),
    .ctrl_in           (ctrl_in),
    .dst_idx_in        (dst_idx_in),
    .execute_result_in (execute_result_in),
    .store_data_in     (store_data_in),
    .stall_out         (stall_out),
    .dmem              (dmem),
    .valid_out         (valid_out),
    .ctrl_out          (ctrl_out),
    .dst_idx_out       (dst_idx_out),
    .wb_data_out       (wb_data_out),
    .misalign_out      (misalign_out),
    .bus_err_out       (bus_err_out)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b0; ctrl_in = '0; dst_idx_in = '0;
    execute_result_in = '0; store_data_in = '0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    step; step;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0h exp 0", valid_out); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %0h exp 0", dmem.dmem_req); end
    vectors++; if ({dmem.dmem_we, dmem.dmem_be, dmem.dmem_addr, dmem.dmem_wdata} !== 69'd0) begin miscompares++; $display("FAIL rst_bus got %0h exp 0", {dmem.dmem_we, dmem.dmem_be, dmem.dmem_addr, dmem.dmem_wdata}); end
    vectors++; if ({ctrl_out, dst_idx_out, wb_data_out} !== 42'd0) begin miscompares++; $display("FAIL rst_wb got %0h exp 0", {ctrl_out, dst_idx_out, wb_data_out}); end
    vectors++; if ({misalign_out, bus_err_out, stall_out} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %0b exp 000", {misalign_out, bus_err_out, stall_out}); end
    rst = 1'b0;
    dmem.dmem_ack = 1'b1;
    step;
    dmem.dmem_ack = 1'b0;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL idle_valid got %0h exp 0", valid_out); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL idle_ack_req got %0h exp 0", dmem.dmem_req); end
  endtask

  task automatic test_passthrough;
    valid_in = 1'b1; ctrl_in = 7'b000_0100; dst_idx_in = 3'd4; execute_result_in = 32'hDEADBEEF;
    #1;
    vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL alu_stall got %0h exp 0", stall_out); end
    step;
    valid_in = 1'b0;
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL alu_valid got %0h exp 1", valid_out); end
    vectors++; if (wb_data_out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL alu_wb got %h exp deadbeef", wb_data_out); end
    vectors++; if (dst_idx_out !== 3'd4) begin miscompares++; $display("FAIL alu_dst got %0d exp 4", dst_idx_out); end
    vectors++; if (ctrl_out !== 7'b000_0100) begin miscompares++; $display("FAIL alu_ctrl got %b exp 0000100", ctrl_out); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL alu_req got %0h exp 0", dmem.dmem_req); end
  endtask

  task automatic test_load_byte;
    valid_in = 1'b1; ctrl_in = 7'b110_0101; dst_idx_in = 3'd3; execute_result_in = 32'h0000_1003;
    #1;
    vectors++; if (stall_out !== 1'b1) begin miscompares++; $display("FAIL lb_stall_accept got %0h exp 1", stall_out); end
    step;
    valid_in = 1'b0;
    vectors++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_we !== 1'b0) begin miscompares++; $display("FAIL lb_req_we got %0b%0b exp 10", dmem.dmem_req, dmem.dmem_we); end
    vectors++; if (dmem.dmem_addr !== 32'h0000_1000) begin miscompares++; $display("FAIL lb_addr got %h exp 00001000", dmem.dmem_addr); end
    vectors++; if (dmem.dmem_be !== 4'b1000) begin miscompares++; $display("FAIL lb_be got %b exp 1000", dmem.dmem_be); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL lb_valid_req got %0h exp 0", valid_out); end
    vectors++; if (stall_out !== 1'b1) begin miscompares++; $display("FAIL lb_stall_req1 got %0h exp 1", stall_out); end
    step;
    vectors++; if (stall_out !== 1'b1) begin miscompares++; $display("FAIL lb_stall_req2 got %0h exp 1", stall_out); end
    step;
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h8011_2233;
    #1;
    vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL lb_stall_ack got %0h exp 0", stall_out); end
    step;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL lb_valid got %0h exp 1", valid_out); end
    vectors++; if (wb_data_out !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_wb got %h exp ffffff80", wb_data_out); end
    vectors++; if (dst_idx_out !== 3'd3) begin miscompares++; $display("FAIL lb_dst got %0d exp 3", dst_idx_out); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL lb_req_done got %0h exp 0", dmem.dmem_req); end
  endtask

  task automatic test_store_half;
    valid_in = 1'b1; ctrl_in = 7'b000_1010; dst_idx_in = 3'd0;
    execute_result_in = 32'h0000_2002; store_data_in = 32'h0000_ABCD;
    step;
    valid_in = 1'b0;
    vectors++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_we !== 1'b1) begin miscompares++; $display("FAIL sh_req_we got %0b%0b exp 11", dmem.dmem_req, dmem.dmem_we); end
    vectors++; if (dmem.dmem_be !== 4'b1100) begin miscompares++; $display("FAIL sh_be got %b exp 1100", dmem.dmem_be); end
    vectors++; if (dmem.dmem_wdata !== 32'hABCD_ABCD) begin miscompares++; $display("FAIL sh_wdata got %h exp abcdabcd", dmem.dmem_wdata); end
    vectors++; if (dmem.dmem_addr !== 32'h0000_2000) begin miscompares++; $display("FAIL sh_addr got %h exp 00002000", dmem.dmem_addr); end
    dmem.dmem_ack = 1'b1;
    #1;
    vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL sh_stall_ack got %0h exp 0", stall_out); end
    step;
    dmem.dmem_ack = 1'b0;
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL sh_valid got %0h exp 1", valid_out); end
    vectors++; if (wb_data_out !== 32'h0000_2002) begin miscompares++; $display("FAIL sh_wb got %h exp 00002002", wb_data_out); end
    step;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL sh_valid_drop got %0h exp 0", valid_out); end
  endtask

  task automatic test_misalign;
    valid_in = 1'b1; ctrl_in = 7'b101_0101; execute_result_in = 32'h0000_3001;
    #1;
    vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL mis_stall got %0h exp 0", stall_out); end
    step;
    valid_in = 1'b0;
    vectors++; if (misalign_out !== 1'b1) begin miscompares++; $display("FAIL mis_pulse got %0h exp 1", misalign_out); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL mis_req got %0h exp 0", dmem.dmem_req); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL mis_valid got %0h exp 0", valid_out); end
    step;
    vectors++; if (misalign_out !== 1'b0) begin miscompares++; $display("FAIL mis_pulse_end got %0h exp 0", misalign_out); end
  endtask

  task automatic test_back_to_back;
    valid_in = 1'b1; ctrl_in = 7'b101_0101; dst_idx_in = 3'd5; execute_result_in = 32'h0000_4000;
    step;
    vectors++; if (dmem.dmem_be !== 4'b1111 || dmem.dmem_req !== 1'b1) begin miscompares++; $display("FAIL b2b_lw_req got %b/%0h exp 1111/1", dmem.dmem_be, dmem.dmem_req); end
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h1234_5678;
    ctrl_in = 7'b100_0001; dst_idx_in = 3'd6; execute_result_in = 32'h0000_4001;
    step;
    dmem.dmem_ack = 1'b0;
    vectors++; if (valid_out !== 1'b1 || wb_data_out !== 32'h1234_5678) begin miscompares++; $display("FAIL b2b_lw_wb got %0h/%h exp 1/12345678", valid_out, wb_data_out); end
    vectors++; if (stall_out !== 1'b1) begin miscompares++; $display("FAIL b2b_lbu_stall got %0h exp 1", stall_out); end
    step;
    vectors++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_be !== 4'b0010) begin miscompares++; $display("FAIL b2b_lbu_req got %0h/%b exp 1/0010", dmem.dmem_req, dmem.dmem_be); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL b2b_lbu_valid0 got %0h exp 0", valid_out); end
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h0000_A500;
    ctrl_in = 7'b110_1001; dst_idx_in = 3'd7; execute_result_in = 32'h0000_5002;
    step;
    dmem.dmem_ack = 1'b0;
    vectors++; if (wb_data_out !== 32'h0000_00A5 || dst_idx_out !== 3'd6) begin miscompares++; $display("FAIL b2b_lbu_wb got %h/%0d exp 000000a5/6", wb_data_out, dst_idx_out); end
    step;
    valid_in = 1'b0;
    vectors++; if (dmem.dmem_be !== 4'b1100 || dmem.dmem_addr !== 32'h0000_5000) begin miscompares++; $display("FAIL b2b_lh_req got %b/%h exp 1100/00005000", dmem.dmem_be, dmem.dmem_addr); end
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h8001_1234;
    step;
    dmem.dmem_ack = 1'b0;
    vectors++; if (wb_data_out !== 32'hFFFF_8001 || valid_out !== 1'b1) begin miscompares++; $display("FAIL b2b_lh_wb got %h/%0h exp ffff8001/1", wb_data_out, valid_out); end
  endtask

  task automatic test_reset_mid_req;
    valid_in = 1'b1; ctrl_in = 7'b001_0010; execute_result_in = 32'h0000_6000; store_data_in = 32'h1122_3344;
    step;
    valid_in = 1'b0;
    vectors++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_wdata !== 32'h1122_3344) begin miscompares++; $display("FAIL rq_req got %0h/%h exp 1/11223344", dmem.dmem_req, dmem.dmem_wdata); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL rq_abort_req got %0h exp 0", dmem.dmem_req); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rq_abort_valid got %0h exp 0", valid_out); end
    step;
    vectors++; if ({valid_out, bus_err_out, stall_out} !== 3'b000) begin miscompares++; $display("FAIL rq_after got %b exp 000", {valid_out, bus_err_out, stall_out}); end
  endtask

  task automatic test_timeout;
    valid_in = 1'b1; ctrl_in = 7'b101_0101; dst_idx_in = 3'd1; execute_result_in = 32'h0000_7000;
    step;
    valid_in = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      vectors++; if (stall_out !== 1'b1) begin miscompares++; $display("FAIL to_stall_c%0d got %0h exp 1", i, stall_out); end
      step;
    end
    vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL to_stall_release got %0h exp 0", stall_out); end
    step;
    vectors++; if (bus_err_out !== 1'b1) begin miscompares++; $display("FAIL to_bus_err got %0h exp 1", bus_err_out); end
    vectors++; if (dmem.dmem_req !== 1'b0 || valid_out !== 1'b0) begin miscompares++; $display("FAIL to_req_valid got %0h/%0h exp 0/0", dmem.dmem_req, valid_out); end
    step;
    vectors++; if (bus_err_out !== 1'b0) begin miscompares++; $display("FAIL to_bus_err_end got %0h exp 0", bus_err_out); end
`else
    for (int i = 0; i < 20; i++) begin
      vectors++; if (stall_out !== 1'b1 || dmem.dmem_req !== 1'b1 || bus_err_out !== 1'b0) begin miscompares++; $display("FAIL wait_c%0d got %0h%0h%0h exp 110", i, stall_out, dmem.dmem_req, bus_err_out); end
      step;
    end
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h0BAD_F00D;
    step;
    dmem.dmem_ack = 1'b0;
    vectors++; if (valid_out !== 1'b1 || wb_data_out !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL wait_done got %0h/%h exp 1/0badf00d", valid_out, wb_data_out); end
`endif
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_load_byte;
    test_store_half;
    test_misalign;
    test_back_to_back;
    test_reset_mid_req;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
